// File: rtl/data_bus_arbiter.sv
// Two-master round-robin arbiter and sequencer for the single-ported data memory.
// Latency: read ack at grant+2+MEM_LAT, write ack at grant+2 (grant = IDLE sample cycle).
// Backpressure: a waiting master sees no ack; m0_stall holds the CPU until its ack.
module data_bus_arbiter #(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 64,
    parameter int MEM_LAT = 1     // memory read latency, legal range 1..4
) (
    input  logic              clk,
    input  logic              rst,

    // Master 0: CPU data port
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_stall,

    // Master 1: loader/debug port
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,

    // Memory side
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    // Status
    output logic [1:0]        gnt,
    output logic [31:0]       m0_count,
    output logic [31:0]       m1_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Value loaded into the latency counter when a read leaves ISSUE.
    localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t            state_q,     state_d;
    logic [2:0]        lat_cnt_q,   lat_cnt_d;
    logic              win_q,       win_d;       // 0 = master 0, 1 = master 1
    logic              last_gnt_q,  last_gnt_d;  // index of the last completed winner
    logic [1:0]        gnt_q,       gnt_d;
    logic              cmd_we_q,    cmd_we_d;
    logic [ADDR_W-1:0] cmd_addr_q,  cmd_addr_d;
    logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
    logic [DATA_W-1:0] rdata0_q,    rdata0_d;
    logic [DATA_W-1:0] rdata1_q,    rdata1_d;
    logic [31:0]       count0_q,    count0_d;
    logic [31:0]       count1_q,    count1_d;

    // Strobes from the sequencer to the datapath
    logic grant_now;   // IDLE cycle in which a winner is chosen
    logic capture;     // last WAIT cycle: mem_rdata is valid
    logic finish;      // DONE cycle: ack, count, release

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic any_req;
    logic pick;        // index of the master that wins this IDLE cycle

    // On a tie the master that did not win last time goes first; otherwise the lone requester wins.
    always_comb begin
        any_req = m0_req | m1_req;
        pick    = (m0_req & m1_req) ? ~last_gnt_q : m1_req;
    end

    // ------------------------------------------------------------------
    // Sequencer: next state and latency counting
    // ------------------------------------------------------------------
    // Reads wait MEM_LAT cycles; the counter is decremented in WAIT and the
    // cycle in which it is about to hit zero is the one carrying valid data.
    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        grant_now = 1'b0;
        capture   = 1'b0;
        finish    = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_now = 1'b1;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (cmd_we_q) begin
                    state_d = DONE;
                end else begin
                    lat_cnt_d = LAT_LOAD;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                lat_cnt_d = lat_cnt_q - 3'd1;
                if (lat_cnt_q == 3'd1) begin
                    capture = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                finish  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: command latch, read-data capture, counters, grant tracking
    // ------------------------------------------------------------------
    // The command is frozen at grant so later requester changes cannot leak into the access.
    always_comb begin
        win_d       = win_q;
        last_gnt_d  = last_gnt_q;
        gnt_d       = gnt_q;
        cmd_we_d    = cmd_we_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        count0_d    = count0_q;
        count1_d    = count1_q;

        if (grant_now) begin
            win_d       = pick;
            gnt_d       = pick ? 2'b10 : 2'b01;
            cmd_we_d    = pick ? m1_we    : m0_we;
            cmd_addr_d  = pick ? m1_addr  : m0_addr;
            cmd_wdata_d = pick ? m1_wdata : m0_wdata;
        end

        if (capture) begin
            if (win_q) begin
                rdata1_d = mem_rdata;
            end else begin
                rdata0_d = mem_rdata;
            end
        end

        if (finish) begin
            last_gnt_d = win_q;
            gnt_d      = 2'b00;
            if (win_q) begin
                count1_d = count1_q + 32'd1;
            end else begin
                count0_d = count0_q + 32'd1;
            end
        end
    end

    // State register; reset drops any in-flight transaction without an ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            lat_cnt_q <= 3'd0;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
        end
    end

    // Datapath registers; last_gnt starts at 1 so master 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_q       <= 1'b0;
            last_gnt_q  <= 1'b1;
            gnt_q       <= 2'b00;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            count0_q    <= 32'd0;
            count1_q    <= 32'd0;
        end else begin
            win_q       <= win_d;
            last_gnt_q  <= last_gnt_d;
            gnt_q       <= gnt_d;
            cmd_we_q    <= cmd_we_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
            count0_q    <= count0_d;
            count1_q    <= count1_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Strobes are decoded from state so they fall to zero the instant reset hits.
    always_comb begin
        mem_en    = (state_q == ISSUE);
        mem_we    = (state_q == ISSUE) & cmd_we_q;
        mem_addr  = cmd_addr_q;
        mem_wdata = cmd_wdata_q;
        m0_ack    = (state_q == DONE) & ~win_q;
        m1_ack    = (state_q == DONE) &  win_q;
        m0_rdata  = rdata0_q;
        m1_rdata  = rdata1_q;
        m0_stall  = m0_req & ~m0_ack;
        gnt       = gnt_q;
        m0_count  = count0_q;
        m1_count  = count1_q;
    end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed bench for data_bus_arbiter: cycle table on a MEM_LAT=1 instance,
// plus hand sequences for contention, MEM_LAT=3 timing and reset during WAIT (MEM_LAT=4).
// All three instances share the input stimulus; each sequence starts from reset.
module tb_data_bus_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        m0_req, m0_we, m1_req, m1_we;
    logic [63:0] m0_addr, m0_wdata, m1_addr, m1_wdata, mem_rdata;

    logic        d1_m0_ack, d1_m1_ack, d1_m0_stall, d1_mem_en, d1_mem_we;
    logic [63:0] d1_m0_rdata, d1_m1_rdata, d1_mem_addr, d1_mem_wdata;
    logic [1:0]  d1_gnt;
    logic [31:0] d1_m0_count, d1_m1_count;

    logic        d3_m0_ack, d3_m1_ack, d3_m0_stall, d3_mem_en, d3_mem_we;
    logic [63:0] d3_m0_rdata, d3_m1_rdata, d3_mem_addr, d3_mem_wdata;
    logic [1:0]  d3_gnt;
    logic [31:0] d3_m0_count, d3_m1_count;

    logic        d4_m0_ack, d4_m1_ack, d4_m0_stall, d4_mem_en, d4_mem_we;
    logic [63:0] d4_m0_rdata, d4_m1_rdata, d4_mem_addr, d4_mem_wdata;
    logic [1:0]  d4_gnt;
    logic [31:0] d4_m0_count, d4_m1_count;

    data_bus_arbiter #(.DATA_W(64), .ADDR_W(64), .MEM_LAT(1)) u_d1 (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(d1_m0_ack), .m0_rdata(d1_m0_rdata), .m0_stall(d1_m0_stall),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(d1_m1_ack), .m1_rdata(d1_m1_rdata),
        .mem_en(d1_mem_en), .mem_we(d1_mem_we), .mem_addr(d1_mem_addr),
        .mem_wdata(d1_mem_wdata), .mem_rdata(mem_rdata),
        .gnt(d1_gnt), .m0_count(d1_m0_count), .m1_count(d1_m1_count)
    );

    data_bus_arbiter #(.DATA_W(64), .ADDR_W(64), .MEM_LAT(3)) u_d3 (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(d3_m0_ack), .m0_rdata(d3_m0_rdata), .m0_stall(d3_m0_stall),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(d3_m1_ack), .m1_rdata(d3_m1_rdata),
        .mem_en(d3_mem_en), .mem_we(d3_mem_we), .mem_addr(d3_mem_addr),
        .mem_wdata(d3_mem_wdata), .mem_rdata(mem_rdata),
        .gnt(d3_gnt), .m0_count(d3_m0_count), .m1_count(d3_m1_count)
    );

    data_bus_arbiter #(.DATA_W(64), .ADDR_W(64), .MEM_LAT(4)) u_d4 (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(d4_m0_ack), .m0_rdata(d4_m0_rdata), .m0_stall(d4_m0_stall),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(d4_m1_ack), .m1_rdata(d4_m1_rdata),
        .mem_en(d4_mem_en), .mem_we(d4_mem_we), .mem_addr(d4_mem_addr),
        .mem_wdata(d4_mem_wdata), .mem_rdata(mem_rdata),
        .gnt(d4_gnt), .m0_count(d4_m0_count), .m1_count(d4_m1_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic set_in(input logic r0, input logic w0, input logic [63:0] a0, input logic [63:0] wd0,
                          input logic r1, input logic w1, input logic [63:0] a1, input logic [63:0] wd1,
                          input logic [63:0] rd);
        m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = wd0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = wd1;
        mem_rdata = rd;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        set_in(0, 0, 64'h0, 64'h0, 0, 0, 64'h0, 64'h0, 64'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One cycle of stimulus and the outputs required during that same cycle (MEM_LAT=1 instance).
    typedef struct {
        logic        r0, w0;
        logic [63:0] a0, wd0;
        logic        r1, w1;
        logic [63:0] a1, wd1;
        logic [63:0] rd;
        logic        e_en, e_we;
        logic [63:0] e_addr, e_wdata;
        logic        e_ack0, e_ack1;
        logic [1:0]  e_gnt;
        logic        e_stall;
        logic [63:0] e_rd0, e_rd1;
        logic [31:0] e_cnt0, e_cnt1;
    } vec_t;

    function automatic vec_t mk(
        input logic r0, input logic w0, input logic [63:0] a0, input logic [63:0] wd0,
        input logic r1, input logic w1, input logic [63:0] a1, input logic [63:0] wd1,
        input logic [63:0] rd,
        input logic en, input logic we, input logic [63:0] ea, input logic [63:0] ed,
        input logic k0, input logic k1, input logic [1:0] g, input logic st,
        input logic [63:0] q0, input logic [63:0] q1, input logic [31:0] c0, input logic [31:0] c1);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.wd0 = wd0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.wd1 = wd1; v.rd = rd;
        v.e_en = en; v.e_we = we; v.e_addr = ea; v.e_wdata = ed;
        v.e_ack0 = k0; v.e_ack1 = k1; v.e_gnt = g; v.e_stall = st;
        v.e_rd0 = q0; v.e_rd1 = q1; v.e_cnt0 = c0; v.e_cnt1 = c1;
        return v;
    endfunction

    localparam logic [63:0] DB = 64'hDEAD_BEEF;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        vec_t vecs[13];
        logic [1:0] grants[$];
        logic [1:0] prev_gnt;
        logic       bad_gnt;
        logic [7:0] en_hist, ack_hist;
        logic [63:0] rd_cap, addr_cap;
        logic       ack_seen, got_gnt;

        // --- single read (m0, 0x40), single write (m1, 0x1234 @ 0x10), latched m0 write ---
        //                r0 w0 a0      wd0     r1 w1 a1      wd1       rd          en we addr    wdata      k0 k1 gnt    st rd0 rd1    c0 c1
        vecs[0]  = mk(1, 0, 64'h40, 64'h0,  0, 0, 64'h0,  64'h0,    64'h1111,   0, 0, 64'h0,  64'h0,     0, 0, 2'b00, 1, 64'h0, 64'h0, 0, 0);
        vecs[1]  = mk(1, 0, 64'h40, 64'h0,  0, 0, 64'h0,  64'h0,    64'h2222,   1, 0, 64'h40, 64'h0,     0, 0, 2'b01, 1, 64'h0, 64'h0, 0, 0);
        vecs[2]  = mk(1, 0, 64'h40, 64'h0,  0, 0, 64'h0,  64'h0,    DB,         0, 0, 64'h40, 64'h0,     0, 0, 2'b01, 1, 64'h0, 64'h0, 0, 0);
        vecs[3]  = mk(1, 0, 64'h40, 64'h0,  0, 0, 64'h0,  64'h0,    64'h3333,   0, 0, 64'h40, 64'h0,     1, 0, 2'b01, 0, DB,    64'h0, 0, 0);
        vecs[4]  = mk(0, 0, 64'h40, 64'h0,  0, 0, 64'h0,  64'h0,    64'h0,      0, 0, 64'h40, 64'h0,     0, 0, 2'b00, 0, DB,    64'h0, 1, 0);
        vecs[5]  = mk(0, 0, 64'h0,  64'h0,  1, 1, 64'h10, 64'h1234, 64'h0,      0, 0, 64'h40, 64'h0,     0, 0, 2'b00, 0, DB,    64'h0, 1, 0);
        vecs[6]  = mk(0, 0, 64'h0,  64'h0,  1, 1, 64'h10, 64'h1234, 64'h0,      1, 1, 64'h10, 64'h1234,  0, 0, 2'b10, 0, DB,    64'h0, 1, 0);
        vecs[7]  = mk(0, 0, 64'h0,  64'h0,  1, 1, 64'h10, 64'h1234, 64'h4444,   0, 0, 64'h10, 64'h1234,  0, 1, 2'b10, 0, DB,    64'h0, 1, 0);
        vecs[8]  = mk(0, 0, 64'h0,  64'h0,  0, 0, 64'h10, 64'h1234, 64'h0,      0, 0, 64'h10, 64'h1234,  0, 0, 2'b00, 0, DB,    64'h0, 1, 1);
        vecs[9]  = mk(1, 1, 64'h80, 64'h55, 0, 0, 64'h0,  64'h0,    64'h0,      0, 0, 64'h10, 64'h1234,  0, 0, 2'b00, 1, DB,    64'h0, 1, 1);
        vecs[10] = mk(1, 0, 64'hFF, 64'h66, 0, 0, 64'h0,  64'h0,    64'h0,      1, 1, 64'h80, 64'h55,    0, 0, 2'b01, 1, DB,    64'h0, 1, 1);
        vecs[11] = mk(1, 0, 64'hFF, 64'h66, 0, 0, 64'h0,  64'h0,    64'h5555,   0, 0, 64'h80, 64'h55,    1, 0, 2'b01, 0, DB,    64'h0, 1, 1);
        vecs[12] = mk(0, 0, 64'hFF, 64'h66, 0, 0, 64'h0,  64'h0,    64'h0,      0, 0, 64'h80, 64'h55,    0, 0, 2'b00, 0, DB,    64'h0, 2, 1);

        set_in(0, 0, 64'h0, 64'h0, 0, 0, 64'h0, 64'h0, 64'h0);
        do_reset();

        // Reset state
        #1;
        check("reset.outputs",
              {d1_mem_en, d1_mem_we, d1_m0_ack, d1_m1_ack, d1_m0_stall, d1_gnt, 57'h0},
              64'h0);
        check("reset.mem_addr", d1_mem_addr, 64'h0);
        check("reset.rdata", d1_m0_rdata | d1_m1_rdata | d1_mem_wdata, 64'h0);
        check("reset.counts", {d1_m0_count, d1_m1_count}, 64'h0);

        // Cycle table
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            set_in(vecs[i].r0, vecs[i].w0, vecs[i].a0, vecs[i].wd0,
                   vecs[i].r1, vecs[i].w1, vecs[i].a1, vecs[i].wd1, vecs[i].rd);
            #1;
            check($sformatf("vec%0d.mem_en",    i), 64'(d1_mem_en),    64'(vecs[i].e_en));
            check($sformatf("vec%0d.mem_we",    i), 64'(d1_mem_we),    64'(vecs[i].e_we));
            check($sformatf("vec%0d.mem_addr",  i), d1_mem_addr,       vecs[i].e_addr);
            check($sformatf("vec%0d.mem_wdata", i), d1_mem_wdata,      vecs[i].e_wdata);
            check($sformatf("vec%0d.m0_ack",    i), 64'(d1_m0_ack),    64'(vecs[i].e_ack0));
            check($sformatf("vec%0d.m1_ack",    i), 64'(d1_m1_ack),    64'(vecs[i].e_ack1));
            check($sformatf("vec%0d.gnt",       i), 64'(d1_gnt),       64'(vecs[i].e_gnt));
            check($sformatf("vec%0d.m0_stall",  i), 64'(d1_m0_stall),  64'(vecs[i].e_stall));
            check($sformatf("vec%0d.m0_rdata",  i), d1_m0_rdata,       vecs[i].e_rd0);
            check($sformatf("vec%0d.m1_rdata",  i), d1_m1_rdata,       vecs[i].e_rd1);
            check($sformatf("vec%0d.m0_count",  i), 64'(d1_m0_count),  64'(vecs[i].e_cnt0));
            check($sformatf("vec%0d.m1_count",  i), 64'(d1_m1_count),  64'(vecs[i].e_cnt1));
        end

        // --- contention right after reset: writes from both, m1 leaves after 2 grants, m0 after 3 ---
        do_reset();
        prev_gnt = 2'b00;
        bad_gnt  = 1'b0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            set_in(c < 15, 1, 64'h100, 64'hA0, c < 12, 1, 64'h200, 64'hB0, 64'h0);
            #1;
            if (d1_gnt == 2'b11) bad_gnt = 1'b1;
            if (d1_gnt != 2'b00 && prev_gnt == 2'b00) grants.push_back(d1_gnt);
            prev_gnt = d1_gnt;
        end
        check("contention.never_11", 64'(bad_gnt), 64'h0);
        check("contention.n_grants", 64'(grants.size()), 64'd5);
        for (int k = 0; k < grants.size() && k < 5; k++) begin
            check($sformatf("contention.grant%0d", k), 64'(grants[k]), (k % 2 == 0) ? 64'h1 : 64'h2);
        end
        check("counters.m0_count", 64'(d1_m0_count), 64'd3);
        check("counters.m1_count", 64'(d1_m1_count), 64'd2);

        // --- long latency on MEM_LAT=3: m0 read of 0x200, memory shows A000+cycle ---
        do_reset();
        en_hist  = '0;
        ack_hist = '0;
        rd_cap   = '0;
        addr_cap = '0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            set_in(c < 6, 0, 64'h200, 64'h0, 0, 0, 64'h0, 64'h0, 64'hA000 + 64'(c));
            #1;
            en_hist[c]  = d3_mem_en;
            ack_hist[c] = d3_m0_ack;
            if (c == 1) addr_cap = d3_mem_addr;
            if (c == 5) rd_cap = d3_m0_rdata;
        end
        check("lat3.mem_en_cycles", 64'(en_hist),  64'h02);
        check("lat3.ack_cycles",    64'(ack_hist), 64'h20);
        check("lat3.mem_addr",      addr_cap,      64'h200);
        check("lat3.rdata",         rd_cap,        64'hA004);

        // --- reset during WAIT on MEM_LAT=4 ---
        do_reset();
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (c < 3) set_in(0, 0, 64'h0, 64'h0, 1, 1, 64'h30, 64'h77, 64'h0);
            else       set_in(1, 0, 64'h50, 64'h0, 0, 0, 64'h0, 64'h0, 64'h9999);
        end
        #1;
        check("rstwait.pre_gnt",      64'(d4_gnt),      64'h1);
        check("rstwait.pre_mem_addr", d4_mem_addr,      64'h50);
        check("rstwait.pre_m1_count", 64'(d4_m1_count), 64'h1);
        m1_req = 1'b1;
        rst    = 1'b1;
        #1;
        check("rstwait.strobes_zero",
              {56'h0, d4_mem_en, d4_mem_we, d4_m0_ack, d4_m1_ack, d4_gnt, 2'b00}, 64'h0);
        check("rstwait.data_zero", d4_mem_addr | d4_mem_wdata | d4_m0_rdata | d4_m1_rdata, 64'h0);
        check("rstwait.counts_zero", {d4_m0_count, d4_m1_count}, 64'h0);
        ack_seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            #1;
            ack_seen = ack_seen | d4_m0_ack | d4_m1_ack;
        end
        rst = 1'b0;
        got_gnt = 1'b0;
        for (int c = 0; c < 8 && !got_gnt; c++) begin
            @(negedge clk);
            #1;
            if (d4_gnt != 2'b00) got_gnt = 1'b1;
            else ack_seen = ack_seen | d4_m0_ack | d4_m1_ack;
        end
        check("rstwait.no_ack",     64'(ack_seen), 64'h0);
        check("rstwait.regranted",  64'(got_gnt),  64'h1);
        check("rstwait.first_gnt",  64'(d4_gnt),   64'h1);

        set_in(0, 0, 64'h0, 64'h0, 0, 0, 64'h0, 64'h0, 64'h0);
        repeat (10) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
